fust_scoreboard: RTL

//  Parametrised scoreboard for the scalar/matrix dispatch path. Holds one status row per function

---
 rtl/fust_scoreboard.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fust_scoreboard.sv
// Per-FU status rows plus a register result-status table for the scalar/matrix dispatch path.
// Dispatch is gated on structural and WAW hazards, operand read on RAW, and writeback on WAR.
module fust_scoreboard #(
    parameter  int NUM_FU   = 4,
    parameter  int NUM_REG  = 32,
    parameter  int ZERO_REG = 1,
    localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int REG_W    = $clog2(NUM_REG)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [FU_W-1:0]   disp_fu,
    input  logic              disp_wen,
    input  logic [REG_W-1:0]  disp_rd,
    input  logic [REG_W-1:0]  disp_rs1,
    input  logic [REG_W-1:0]  disp_rs2,
    output logic              disp_ready,
    output logic [NUM_FU-1:0] rdop_ready,
    input  logic [NUM_FU-1:0] rdop_ack,
    input  logic [NUM_FU-1:0] wb_req,
    output logic [NUM_FU-1:0] wb_grant,
    output logic [NUM_FU-1:0] busy
);

    logic [NUM_FU-1:0] rd_done;
    logic [NUM_FU-1:0] wen;
    logic [NUM_FU-1:0] rj;
    logic [NUM_FU-1:0] rk;
    logic [NUM_FU-1:0] t1v;
    logic [NUM_FU-1:0] t2v;
    logic [REG_W-1:0]  r    [NUM_FU];
    logic [REG_W-1:0]  r1   [NUM_FU];
    logic [REG_W-1:0]  r2   [NUM_FU];
    logic [FU_W-1:0]   t1   [NUM_FU];
    logic [FU_W-1:0]   t2   [NUM_FU];

    logic [NUM_REG-1:0] rstat_v;
    logic [FU_W-1:0]    rstat_fu [NUM_REG];

    logic              hold;
    logic [NUM_FU-1:0] rd_fire;
    logic [NUM_FU-1:0] war;
    logic [NUM_FU-1:0] elig;
    logic              gnt_any;
    logic [FU_W-1:0]   gnt_idx;

    logic fu_ok;
    logic fu_busy;
    logic wen_eff;
    logic disp_fire;
    logic src1_pend;
    logic src2_pend;

    assign hold = flush || RST;

    // Operand readiness, WAR-filtered writeback eligibility and the fixed-priority grant
    always_comb begin
        rdop_ready = '0;
        war        = '0;
        elig       = '0;
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        wb_grant   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            rdop_ready[f] = busy[f] && rj[f] && rk[f] && !rd_done[f] && !hold;
            for (int g = 0; g < NUM_FU; g++) begin
                if (g != f && busy[g] && !rd_done[g] && wen[f] &&
                    ((r1[g] == r[f] && rj[g]) || (r2[g] == r[f] && rk[g])))
                    war[f] = 1'b1;
            end
            elig[f] = wb_req[f] && busy[f] && rd_done[f] && !war[f] && !hold;
        end
        for (int f = NUM_FU - 1; f >= 0; f--) begin
            if (elig[f]) begin
                gnt_any = 1'b1;
                gnt_idx = FU_W'(f);
            end
        end
        for (int f = 0; f < NUM_FU; f++)
            wb_grant[f] = gnt_any && (gnt_idx == FU_W'(f));
    end

    assign rd_fire = rdop_ready & rdop_ack;

    // A source whose producer is being granted this cycle is treated as already available
    always_comb begin
        fu_ok   = 1'b0;
        fu_busy = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (disp_fu == FU_W'(f)) begin
                fu_ok   = 1'b1;
                fu_busy = busy[f];
            end
        end
        wen_eff    = disp_wen && !((ZERO_REG != 0) && (disp_rd == '0));
        disp_ready = fu_ok && !fu_busy && !(wen_eff && rstat_v[disp_rd]) && !hold;
        disp_fire  = disp_valid && disp_ready;
        src1_pend  = rstat_v[disp_rs1] && !((ZERO_REG != 0) && (disp_rs1 == '0)) &&
                     !(gnt_any && rstat_fu[disp_rs1] == gnt_idx);
        src2_pend  = rstat_v[disp_rs2] && !((ZERO_REG != 0) && (disp_rs2 == '0)) &&
                     !(gnt_any && rstat_fu[disp_rs2] == gnt_idx);
    end

    always_ff @(posedge CLK) begin
        if (hold) begin
            busy    <= '0;
            rd_done <= '0;
            wen     <= '0;
            rj      <= '0;
            rk      <= '0;
            t1v     <= '0;
            t2v     <= '0;
            rstat_v <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                r[f]  <= '0;
                r1[f] <= '0;
                r2[f] <= '0;
                t1[f] <= '0;
                t2[f] <= '0;
            end
            for (int i = 0; i < NUM_REG; i++)
                rstat_fu[i] <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (rd_fire[f]) begin
                    rd_done[f] <= 1'b1;
                    rj[f]      <= 1'b0;
                    rk[f]      <= 1'b0;
                end
            end
            if (gnt_any) begin
                busy[gnt_idx] <= 1'b0;
                if (wen[gnt_idx] && rstat_fu[r[gnt_idx]] == gnt_idx)
                    rstat_v[r[gnt_idx]] <= 1'b0;
                for (int g = 0; g < NUM_FU; g++) begin
                    if (t1v[g] && t1[g] == gnt_idx) begin
                        rj[g]  <= 1'b1;
                        t1v[g] <= 1'b0;
                    end
                    if (t2v[g] && t2[g] == gnt_idx) begin
                        rk[g]  <= 1'b1;
                        t2v[g] <= 1'b0;
                    end
                end
            end
            // The dispatched row is never busy, so it cannot collide with the ack/grant updates
            if (disp_fire) begin
                busy[disp_fu]    <= 1'b1;
                rd_done[disp_fu] <= 1'b0;
                wen[disp_fu]     <= wen_eff;
                r[disp_fu]       <= disp_rd;
                r1[disp_fu]      <= disp_rs1;
                r2[disp_fu]      <= disp_rs2;
                t1[disp_fu]      <= rstat_fu[disp_rs1];
                t2[disp_fu]      <= rstat_fu[disp_rs2];
                t1v[disp_fu]     <= src1_pend;
                t2v[disp_fu]     <= src2_pend;
                rj[disp_fu]      <= !src1_pend;
                rk[disp_fu]      <= !src2_pend;
                if (wen_eff) begin
                    rstat_v[disp_rd]  <= 1'b1;
                    rstat_fu[disp_rd] <= disp_fu;
                end
            end
        end
    end

endmodule
